// File: rtl/instruction_sequencer.sv
// Multi-cycle control sequencer for a 12-bit-address accumulator machine.
// Walks fetch/decode/execute and emits combinational datapath strobes.
module instruction_sequencer #(
    parameter int RETIRE_W = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [3:0]          opcode,
    input  logic                acc_zero,
    input  logic                mem_ack,
    output logic                mem_req,
    output logic                mem_we,
    output logic                mar_write,
    output logic                mbr_write,
    output logic                ir_write,
    output logic                acc_write,
    output logic                pc_inc,
    output logic                pc_write,
    output logic                mar_sel,
    output logic                acc_sel,
    output logic [3:0]          alu_op,
    output logic                busy,
    output logic                halted,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired,
    output logic [3:0]          state
);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_FETCH_ADDR = 4'd1,
        S_FETCH_MEM  = 4'd2,
        S_FETCH_IR   = 4'd3,
        S_DECODE     = 4'd4,
        S_EXEC_MEM   = 4'd5,
        S_EXEC_WB    = 4'd6,
        S_HALTED     = 4'd7
    } state_t;

    localparam logic [3:0] OP_HALT  = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_JUMP  = 4'h8;
    localparam logic [3:0] OP_JZ    = 4'h9;
    localparam logic [3:0] OP_SHL   = 4'hA;
    localparam logic [3:0] OP_SHR   = 4'hB;

    state_t st;
    logic   retire;

    assign state  = st;
    assign busy   = (st != S_IDLE) && (st != S_HALTED);
    assign halted = (st == S_HALTED);

    // retire marks the final cycle of every legal instruction
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mar_write = 1'b0;
        mbr_write = 1'b0;
        ir_write  = 1'b0;
        acc_write = 1'b0;
        pc_inc    = 1'b0;
        pc_write  = 1'b0;
        mar_sel   = 1'b0;
        acc_sel   = 1'b0;
        alu_op    = 4'b0000;
        retire    = 1'b0;
        case (st)
            S_FETCH_ADDR: mar_write = 1'b1;
            S_FETCH_MEM: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    mbr_write = 1'b1;
                    pc_inc    = 1'b1;
                end
            end
            S_FETCH_IR: ir_write = 1'b1;
            S_DECODE: begin
                case (opcode)
                    OP_HALT: retire = 1'b1;
                    OP_JUMP: begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end
                    OP_JZ: begin
                        pc_write = acc_zero;
                        retire   = 1'b1;
                    end
                    OP_SHL, OP_SHR: begin
                        acc_write = 1'b1;
                        alu_op    = (opcode == OP_SHL) ? 4'b0100 : 4'b0101;
                        retire    = 1'b1;
                    end
                    OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        mar_write = 1'b1;
                        mar_sel   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_EXEC_MEM: begin
                mem_req = 1'b1;
                mem_we  = (opcode == OP_STORE);
                if (mem_ack) begin
                    if (opcode == OP_STORE) retire    = 1'b1;
                    else                    mbr_write = 1'b1;
                end
            end
            S_EXEC_WB: begin
                acc_write = 1'b1;
                retire    = 1'b1;
                case (opcode)
                    OP_LOAD: acc_sel = 1'b1;
                    OP_SUB:  alu_op  = 4'b0001;
                    OP_AND:  alu_op  = 4'b1000;
                    OP_OR:   alu_op  = 4'b1001;
                    OP_XOR:  alu_op  = 4'b1010;
                    default: alu_op  = 4'b0000;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            st      <= S_IDLE;
            retired <= '0;
            illegal <= 1'b0;
        end else begin
            if (retire) retired <= retired + RETIRE_W'(1);
            case (st)
                S_IDLE:       if (start) st <= S_FETCH_ADDR;
                S_FETCH_ADDR: st <= S_FETCH_MEM;
                S_FETCH_MEM:  if (mem_ack) st <= S_FETCH_IR;
                S_FETCH_IR:   st <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_HALT: st <= S_HALTED;
                        OP_JUMP, OP_JZ, OP_SHL, OP_SHR: st <= S_FETCH_ADDR;
                        OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
                            st <= S_EXEC_MEM;
                        default: begin
                            illegal <= 1'b1;
                            st      <= S_HALTED;
                        end
                    endcase
                end
                S_EXEC_MEM:
                    if (mem_ack) st <= (opcode == OP_STORE) ? S_FETCH_ADDR : S_EXEC_WB;
                S_EXEC_WB:    st <= S_FETCH_ADDR;
                S_HALTED:     st <= S_HALTED;
                default:      st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: per-instruction expected traces built from
// the opcode rules, compared every cycle, plus hand-computed literal checks.
module tb_instruction_sequencer;

    // Narrow counter so the wrap case is reachable in a short run.
    localparam int RW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    opcode = 4'h0;
    logic          acc_zero = 1'b0;
    logic          mem_ack = 1'b0;
    logic          mem_req, mem_we, mar_write, mbr_write, ir_write, acc_write;
    logic          pc_inc, pc_write, mar_sel, acc_sel, busy, halted, illegal;
    logic [3:0]    alu_op, state;
    logic [RW-1:0] retired;

    instruction_sequencer #(.RETIRE_W(RW)) dut (
        .clock(clock), .reset(reset), .start(start), .opcode(opcode),
        .acc_zero(acc_zero), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
        .mar_write(mar_write), .mbr_write(mbr_write), .ir_write(ir_write),
        .acc_write(acc_write), .pc_inc(pc_inc), .pc_write(pc_write),
        .mar_sel(mar_sel), .acc_sel(acc_sel), .alu_op(alu_op), .busy(busy),
        .halted(halted), .illegal(illegal), .retired(retired), .state(state)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]    st;
        logic          req, we, marw, mbrw, irw, accw, pci, pcw, msel, asel;
        logic [3:0]    alu;
        logic          busy, halted, ill;
        logic [RW-1:0] ret;
    } obs_t;

    typedef struct {
        string  name;
        longint got;
        longint want;
    } lit_t;

    obs_t    exp_q[$];
    lit_t    lit_q[$];
    int      fa_q[$];
    int      n_cmp = 0, n_bad = 0;
    int      cyc = 0, halt_at = 0;
    int      n_req = 0, n_pci = 0, n_mbrw = 0, n_pcw = 0, n_we = 0;
    logic [3:0]    prev_st = 4'h0;
    logic [RW-1:0] exp_ret = '0;
    logic          exp_ill = 1'b0;

    // Single checker: trace records and queued literal checks.
    always @(negedge clock) begin
        obs_t a, e;
        lit_t l;
        a = '{st: state, req: mem_req, we: mem_we, marw: mar_write, mbrw: mbr_write,
              irw: ir_write, accw: acc_write, pci: pc_inc, pcw: pc_write, msel: mar_sel,
              asel: acc_sel, alu: alu_op, busy: busy, halted: halted, ill: illegal,
              ret: retired};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL trace cycle %0d: got %h want %h", cyc, a, e);
            end
        end
        while (lit_q.size() > 0) begin
            l = lit_q.pop_front();
            n_cmp++;
            if (l.got != l.want) begin
                n_bad++;
                $display("FAIL %s: got %0d want %0d", l.name, l.got, l.want);
            end
        end
        cyc++;
        if (state == 4'd1) fa_q.push_back(cyc);
        if (state == 4'd7 && prev_st != 4'd7) halt_at = cyc;
        prev_st = state;
        n_req  += int'(mem_req);
        n_pci  += int'(pc_inc);
        n_mbrw += int'(mbr_write);
        n_pcw  += int'(pc_write);
        n_we   += int'(mem_we);
    end

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [3:0] ro();
        return 4'($urandom);
    endfunction

    function automatic obs_t blank(input logic [3:0] s);
        obs_t e;
        e        = '0;
        e.st     = s;
        e.busy   = (s != 4'd0) && (s != 4'd7);
        e.halted = (s == 4'd7);
        e.ill    = exp_ill;
        e.ret    = exp_ret;
        return e;
    endfunction

    task automatic lit(input string n, input longint g, input longint w);
        lit_t l;
        l = '{n, g, w};
        lit_q.push_back(l);
    endtask

    task automatic drive(input logic s, input logic a, input logic [3:0] o, input logic z);
        start = s; mem_ack = a; opcode = o; acc_zero = z;
    endtask

    task automatic step(input obs_t e);
        exp_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(rb(), rb(), ro(), rb());
        @(posedge clock);
        #1;
        reset   = 1'b0;
        exp_ret = '0;
        exp_ill = 1'b0;
    endtask

    task automatic go();
        drive(1'b1, rb(), ro(), rb());
        step(blank(4'd0));
    endtask

    task automatic halted_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive(rb(), rb(), ro(), rb());
            step(blank(4'd7));
        end
    endtask

    // One instruction from FETCH_ADDR to its last cycle; wf/wx are wait cycles
    // before mem_ack in fetch and execute. abort resets after one exec wait.
    task automatic run_instr(input logic [3:0] op, input int wf, input int wx,
                             input logic az, input bit abort);
        obs_t e;
        drive(rb(), rb(), ro(), rb());
        e = blank(4'd1); e.marw = 1'b1; step(e);
        for (int i = 0; i < wf; i++) begin
            drive(rb(), 1'b0, ro(), rb());
            e = blank(4'd2); e.req = 1'b1; step(e);
        end
        drive(rb(), 1'b1, ro(), rb());
        e = blank(4'd2); e.req = 1'b1; e.mbrw = 1'b1; e.pci = 1'b1; step(e);
        drive(rb(), rb(), ro(), rb());
        e = blank(4'd3); e.irw = 1'b1; step(e);
        drive(rb(), rb(), op, az);
        e = blank(4'd4);
        if (op == 4'h0) begin
            step(e); exp_ret++; return;
        end else if (op == 4'h8 || op == 4'h9) begin
            e.pcw = (op == 4'h8) ? 1'b1 : az;
            step(e); exp_ret++; return;
        end else if (op == 4'hA || op == 4'hB) begin
            e.accw = 1'b1; e.alu = (op == 4'hA) ? 4'b0100 : 4'b0101;
            step(e); exp_ret++; return;
        end else if (op >= 4'hC) begin
            step(e); exp_ill = 1'b1; return;
        end
        e.marw = 1'b1; e.msel = 1'b1; step(e);
        for (int i = 0; i < wx; i++) begin
            drive(rb(), 1'b0, op, rb());
            e = blank(4'd5); e.req = 1'b1; e.we = (op == 4'h2); step(e);
            if (abort) begin
                do_reset();
                return;
            end
        end
        drive(rb(), 1'b1, op, rb());
        e = blank(4'd5); e.req = 1'b1; e.we = (op == 4'h2); e.mbrw = (op != 4'h2);
        step(e);
        if (op == 4'h2) begin
            exp_ret++; return;
        end
        drive(rb(), rb(), op, rb());
        e = blank(4'd6); e.accw = 1'b1;
        case (op)
            4'h1:    e.asel = 1'b1;
            4'h4:    e.alu  = 4'b0001;
            4'h5:    e.alu  = 4'b1000;
            4'h6:    e.alu  = 4'b1001;
            4'h7:    e.alu  = 4'b1010;
            default: e.alu  = 4'b0000;
        endcase
        step(e);
        exp_ret++;
    endtask

    initial begin
        int b, w0, r0, p0, m0, pw0, pw1, pw2;
        logic [RW-1:0] rsave;

        do_reset();
        lit("reset_state", state, 0);
        lit("reset_mem_req", mem_req, 0);
        lit("reset_busy", busy, 0);
        lit("reset_retired", retired, 0);
        drive(1'b0, rb(), ro(), rb());
        step(blank(4'd0));

        // LOAD; ADD; STORE; HALT with zero-wait memory
        b = fa_q.size(); w0 = n_we;
        go();
        run_instr(4'h1, 0, 0, 1'b0, 1'b0);
        run_instr(4'h3, 0, 0, 1'b0, 1'b0);
        run_instr(4'h2, 0, 0, 1'b0, 1'b0);
        run_instr(4'h0, 0, 0, 1'b0, 1'b0);
        halted_cycles(3);
        lit("len_load", fa_q[b+1] - fa_q[b], 6);
        lit("len_add", fa_q[b+2] - fa_q[b+1], 6);
        lit("len_store", fa_q[b+3] - fa_q[b+2], 5);
        lit("len_halt", halt_at - fa_q[b+3], 4);
        lit("prog_retired", retired, 4);
        lit("prog_halted", halted, 1);
        lit("prog_we_cycles", n_we - w0, 1);

        // fetch stalled 3 cycles
        do_reset();
        go();
        r0 = n_req; p0 = n_pci; m0 = n_mbrw;
        run_instr(4'h8, 3, 0, 1'b0, 1'b0);
        lit("stall_req_cycles", n_req - r0, 4);
        lit("stall_pc_inc", n_pci - p0, 1);
        lit("stall_mbr_write", n_mbrw - m0, 1);

        // JZ taken then not taken
        b = fa_q.size(); pw0 = n_pcw;
        run_instr(4'h9, 0, 0, 1'b1, 1'b0);
        pw1 = n_pcw;
        run_instr(4'h9, 0, 0, 1'b0, 1'b0);
        pw2 = n_pcw;
        run_instr(4'hA, 0, 0, 1'b0, 1'b0);
        lit("jz_taken_pcw", pw1 - pw0, 1);
        lit("jz_not_taken_pcw", pw2 - pw1, 0);
        lit("len_jz1", fa_q[b+1] - fa_q[b], 4);
        lit("len_jz2", fa_q[b+2] - fa_q[b+1], 4);

        // illegal opcode
        rsave = retired;
        run_instr(4'hD, 0, 0, 1'b0, 1'b0);
        halted_cycles(4);
        lit("illegal_flag", illegal, 1);
        lit("illegal_state", state, 7);
        lit("illegal_retired", retired, rsave);
        do_reset();
        lit("illegal_cleared", illegal, 0);

        // reset mid-stall in EXEC_MEM
        go();
        run_instr(4'h8, 0, 0, 1'b0, 1'b0);
        run_instr(4'h3, 0, 2, 1'b0, 1'b1);
        lit("abort_state", state, 0);
        lit("abort_mem_req", mem_req, 0);
        lit("abort_retired", retired, 0);
        drive(1'b0, rb(), ro(), rb());
        step(blank(4'd0));

        // counter wrap
        go();
        for (int i = 0; i < (1 << RW) - 1; i++) run_instr(4'h8, 0, 0, 1'b0, 1'b0);
        lit("pre_wrap", retired, (1 << RW) - 1);
        run_instr(4'hB, 0, 0, 1'b0, 1'b0);
        lit("wrap", retired, 0);

        // random legal program with random waits
        for (int i = 0; i < 200; i++)
            run_instr(4'($urandom_range(1, 11)), $urandom_range(0, 3),
                      $urandom_range(0, 3), rb(), 1'b0);
        run_instr(4'h0, $urandom_range(0, 2), 0, rb(), 1'b0);
        halted_cycles(3);

        do_reset();
        go();
        run_instr(4'($urandom_range(12, 15)), $urandom_range(0, 2), 0, rb(), 1'b0);
        halted_cycles(2);

        @(negedge clock);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
